// File: rtl/cpu_pkg.sv
// Shared encodings and default widths for the block-move helper and its neighbours.
package cpu_pkg;
  localparam int CPU_AW = 16;
  localparam int CPU_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } copy_state_e;
endpackage

// File: rtl/mem_copy_wait_ctr.sv
// Read-latency counter: loaded on entry to READ, counts down, flags the last READ cycle.
module mem_copy_wait_ctr #(
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic last
);
  localparam logic [1:0] LOAD_VAL = 2'(READ_LAT - 1);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = LOAD_VAL;
    else if (dec && cnt_q != '0)  cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);
endmodule

// File: rtl/mem_copy_engine.sv
// Block-move initiator: copies Length words src->dst over the DataMemory port, one read then one write per word.
module mem_copy_engine
  import cpu_pkg::*;
#(
  parameter int AW       = CPU_AW,
  parameter int DW       = CPU_DW,
  parameter int READ_LAT = 1
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [AW-1:0] SrcAdresa,
  input  logic [AW-1:0] DstAdresa,
  input  logic [15:0]   Length,
  input  logic          Abort,
  output logic          Busy,
  output logic          Done,
  output logic [15:0]   WordsDone,
  output logic [AW-1:0] Adresa,
  output logic [DW-1:0] WriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [DW-1:0] ReadData
);
  copy_state_e   state_q, state_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d;
  logic [15:0]   rem_q, rem_d, words_q, words_d;
  logic [DW-1:0] data_q, data_d;
  logic          rd_last;

  // Reload the latency counter on every entry into READ, including from WRITE.
  mem_copy_wait_ctr #(.READ_LAT(READ_LAT)) u_wait (
    .clk   (Clock),
    .rst_n (Reset_n),
    .load  (state_d == ST_READ && state_q != ST_READ),
    .dec   (state_q == ST_READ),
    .last  (rd_last)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    words_d = words_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          words_d = '0;
          if (Length != '0) begin
            src_d   = SrcAdresa;
            dst_d   = DstAdresa;
            rem_d   = Length;
            state_d = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_READ: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (rd_last) begin
          data_d  = ReadData;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // The write commits on this edge regardless of Abort, so it is always counted.
        src_d   = src_q + AW'(1);
        dst_d   = dst_q + AW'(1);
        rem_d   = rem_q - 16'd1;
        words_d = words_q + 16'd1;
        if (Abort)               state_d = ST_IDLE;
        else if (rem_q == 16'd1) state_d = ST_DONE;
        else                     state_d = ST_READ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      data_q  <= data_d;
    end
  end

  assign Busy      = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign Done      = (state_q == ST_DONE);
  assign MemRead   = (state_q == ST_READ);
  assign MemWrite  = (state_q == ST_WRITE);
  assign Adresa    = (state_q == ST_READ)  ? src_q :
                     (state_q == ST_WRITE) ? dst_q : '0;
  assign WriteData = data_q;
  assign WordsDone = words_q;
endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: vector table of copy commands plus abort/reset/restart sequences.
module tb_mem_copy_engine;
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [15:0] SrcAdresa = '0, DstAdresa = '0, Length = '0;
  logic        Busy, Done, MemWrite, MemRead;
  logic [15:0] WordsDone, Adresa, WriteData, ReadData;

  logic [15:0] mem   [0:65535];
  logic [15:0] model [0:65535];
  logic [15:0] rd_q [$];
  logic [31:0] wr_q [$];
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    int          pulse_k;
  } vec_t;

  mem_copy_engine #(.AW(16), .DW(16), .READ_LAT(1)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .SrcAdresa(SrcAdresa),
    .DstAdresa(DstAdresa), .Length(Length), .Abort(Abort), .Busy(Busy),
    .Done(Done), .WordsDone(WordsDone), .Adresa(Adresa), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData)
  );

  always #5 Clock = ~Clock;

  assign ReadData = mem[Adresa];
  always @(posedge Clock) if (MemWrite) mem[Adresa] = WriteData;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every bus access is matched against the queued expectation.
  always @(negedge Clock) begin
    if (MemRead) begin
      if (rd_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_read: addr %h, none expected", Adresa);
      end else chk("read_addr", 32'(Adresa), 32'(rd_q.pop_front()));
    end
    if (MemWrite) begin
      if (wr_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL unexpected_write: addr %h data %h, none expected", Adresa, WriteData);
      end else chk("write_addr_data", {Adresa, WriteData}, wr_q.pop_front());
    end
  end

  // Called at #1 after an edge with the engine idle; returns cycle counts relative to the Start edge.
  task automatic do_cmd(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                        input int pulse_k, output int done_at, output int busy_n, output int done_n);
    SrcAdresa = s; DstAdresa = d; Length = l; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    done_at = -1; busy_n = 0; done_n = 0;
    for (int k = 1; k <= 200; k++) begin
      if (k == pulse_k) begin
        Start = 1'b1; SrcAdresa = 16'h0010; Length = 16'd5;
      end else Start = 1'b0;
      if (Done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (Busy) busy_n++;
      if (done_at > 0 && k >= done_at + 3) break;
      @(posedge Clock); #1;
    end
    Start = 1'b0;
    if (done_at < 0) begin
      n_checks++; n_errors++;
      $display("FAIL cmd_timeout: no Done within 200 cycles, src %h len %0d", s, l);
    end
  endtask

  task automatic run_vec(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                         input int pk, input string nm);
    int done_at, busy_n, done_n;
    logic [15:0] a, b;
    for (int i = 0; i < int'(l); i++) begin
      a = s + 16'(i);
      b = d + 16'(i);
      rd_q.push_back(a);
      wr_q.push_back({b, model[a]});
      model[b] = model[a];
    end
    do_cmd(s, d, l, pk, done_at, busy_n, done_n);
    chk({nm, "_done_cycle"}, 32'(done_at), 32'(int'(l) * 2 + 1));
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'(int'(l) * 2));
    chk({nm, "_done_pulses"}, 32'(done_n), 32'd1);
    chk({nm, "_words_done"}, 32'(WordsDone), 32'(l));
    chk({nm, "_rd_pending"}, 32'(rd_q.size()), 32'd0);
    chk({nm, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    for (int i = 0; i < int'(l); i++) begin
      b = d + 16'(i);
      chk({nm, "_mem"}, 32'(mem[b]), 32'(model[b]));
    end
  endtask

  initial begin
    vec_t vecs [5];
    int   n;
    vecs[0] = '{16'h0010, 16'h0040, 16'd3, 0};
    vecs[1] = '{16'h0050, 16'h0060, 16'd0, 0};
    vecs[2] = '{16'hFFFF, 16'h0100, 16'd2, 0};
    vecs[3] = '{16'h0020, 16'h0021, 16'd3, 3};
    vecs[4] = '{16'h0200, 16'h0300, 16'd5, 0};

    for (int i = 0; i < 65536; i++) begin
      mem[i]   = 16'(i) ^ 16'h5A5A;
      model[i] = 16'(i) ^ 16'h5A5A;
    end
    mem[16'h0010] = 16'h1111; mem[16'h0011] = 16'h2222; mem[16'h0012] = 16'h3333;
    mem[16'hFFFF] = 16'hBEEF; mem[16'h0000] = 16'hCAFE; mem[16'h0020] = 16'hABCD;
    model[16'h0010] = 16'h1111; model[16'h0011] = 16'h2222; model[16'h0012] = 16'h3333;
    model[16'hFFFF] = 16'hBEEF; model[16'h0000] = 16'hCAFE; model[16'h0020] = 16'hABCD;

    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
    chk("rst_adresa", 32'(Adresa), 32'd0);
    chk("rst_wdata", 32'(WriteData), 32'd0);
    chk("rst_words", 32'(WordsDone), 32'd0);
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("idle_busy", 32'(Busy), 32'd0);

    for (int v = 0; v < 5; v++)
      run_vec(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].pulse_k, $sformatf("vec%0d", v));
    chk("copy_0x42", 32'(mem[16'h0042]), 32'h3333);
    chk("wrap_0x0101", 32'(mem[16'h0101]), 32'hCAFE);
    chk("overlap_0x23", 32'(mem[16'h0023]), 32'hABCD);

    // Abort during the second READ: only the first word lands.
    rd_q.push_back(16'h0010);
    wr_q.push_back({16'h0070, model[16'h0010]});
    rd_q.push_back(16'h0011);
    model[16'h0070] = model[16'h0010];
    SrcAdresa = 16'h0010; DstAdresa = 16'h0070; Length = 16'd3; Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    @(posedge Clock); #1;
    @(posedge Clock); #1; Abort = 1'b1;
    chk("abort_in_read", 32'(MemRead), 32'd1);
    @(posedge Clock); #1; Abort = 1'b0;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_words", 32'(WordsDone), 32'd1);
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (Done) n++;
      @(posedge Clock); #1;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    chk("abort_mem70", 32'(mem[16'h0070]), 32'h1111);
    chk("abort_mem71", 32'(mem[16'h0071]), 32'(model[16'h0071]));
    chk("abort_rd_pending", 32'(rd_q.size()), 32'd0);
    run_vec(16'h0011, 16'h0071, 16'd2, 0, "after_abort");

    // Asynchronous reset in the middle of a WRITE cycle.
    rd_q.push_back(16'h0010);
    SrcAdresa = 16'h0010; DstAdresa = 16'h0090; Length = 16'd2; Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
    @(posedge Clock); #1;
    chk("pre_reset_write", 32'(MemWrite), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    chk("areset_memwrite", 32'(MemWrite), 32'd0);
    chk("areset_busy", 32'(Busy), 32'd0);
    chk("areset_adresa", 32'(Adresa), 32'd0);
    chk("areset_wdata", 32'(WriteData), 32'd0);
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    Reset_n = 1'b1;
    @(posedge Clock); #1;
    chk("post_reset_idle", 32'({Busy, Done, MemRead, MemWrite}), 32'd0);
    chk("post_reset_mem90", 32'(mem[16'h0090]), 32'(model[16'h0090]));
    chk("post_reset_rd_pending", 32'(rd_q.size()), 32'd0);
    run_vec(16'h0010, 16'h00A0, 16'd1, 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
Bus-initiator block that drives the DataMemory port set (Adresa, WriteData, MemWrite, MemRead, ReadData) from the requester side. On a Start command it copies Length consecutive 16-bit words from a source address region to a destination address region, one read then one write per word. It sits beside the CPU datapath as a block-move/DMA helper and shares DataMemory through an external arbiter, which is out of scope.

Parameters:
AW, 16, address width (Adresa, SrcAdresa, DstAdresa)
DW, 16, data width (WriteData, ReadData)
READ_LAT, 1, cycles MemRead/Adresa are held before ReadData is sampled; legal range 1..4

Ports:
Clock  in  1  single system clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  command strobe, sampled only in IDLE
SrcAdresa  in  AW  first source word address
DstAdresa  in  AW  first destination word address
Length  in  16  number of words to copy; 0 is legal
Abort  in  1  cancel the transfer in progress
Busy  out  1  high while in READ or WRITE
Done  out  1  one-cycle completion pulse
WordsDone  out  16  words written for the current or last command
Adresa  out  AW  memory address
WriteData  out  DW  memory write data
MemWrite  out  1  memory write enable; memory commits on the rising edge
MemRead  out  1  memory read enable
ReadData  in  DW  memory read data

Behaviour:
- Reset (asynchronous, Reset_n=0): state IDLE; all outputs 0; internal src, dst, remaining, data and wait registers all 0. Takes effect immediately, including mid-transfer.
- FSM states are IDLE, READ, WRITE and DONE. Memory strobes are Moore outputs decoded from state only.
- IDLE: Busy, MemRead and MemWrite are 0; Adresa is 0.
  - Start=1 with Length!=0: latch src, dst and remaining=Length; clear WordsDone; go to READ.
  - Start=1 with Length=0: clear WordsDone; go to DONE.
- READ: MemRead=1, Adresa=src. The wait counter runs for READ_LAT cycles. At the edge ending the last cycle, capture ReadData into the data register and go to WRITE.
- WRITE: one cycle with MemWrite=1, Adresa=dst, WriteData=data register. At the edge ending the cycle:
  - src+1 and dst+1, both mod 2^AW (0xFFFF wraps to 0x0000);
  - remaining-1 and WordsDone+1;
  - go to DONE if remaining becomes 0, else to READ.
- DONE: Done=1 for exactly one cycle, Busy=0, then go to IDLE.
- WriteData holds the data register in all states. It is 0 until the first capture.
- Per-word cost is READ_LAT+1 cycles. Done is high in the cycle starting Length*(READ_LAT+1)+1 edges after the Start edge. For Length=0, Done is high in the cycle after the Start edge.
- Start is ignored in READ, WRITE and DONE.
- Abort=1 in READ or WRITE: go to IDLE at the next edge, with no Done pulse. A write in the WRITE cycle where Abort is sampled still commits, because the memory samples the same edge; WordsDone counts it. Abort is ignored in IDLE and DONE.
- Copying is always ascending. Overlapping regions are not special-cased: dst=src+1 replicates the first word.

Decomposition:
- Shared package (cpu_pkg): state encoding constants, with IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3; width constants for AW and DW.
- Optional sub-module mem_copy_wait_ctr: a load/decrement counter producing the last-read-cycle flag. Inlining it is also acceptable.

Test Plan:
- Preload mem[0x10..0x12]=0x1111,0x2222,0x3333; Start with Src=0x10, Dst=0x40, Length=3 (READ_LAT=1) -> mem[0x40..0x42] hold the same values; Busy high 6 cycles; Done pulse in cycle 7 after the Start edge; WordsDone=3.
- Start with Length=0 -> Done high in the next cycle; MemRead and MemWrite never asserted; WordsDone=0.
- Src=0xFFFF, Dst=0x0100, Length=2 -> reads at Adresa 0xFFFF then 0x0000; writes at 0x0100 and 0x0101.
- Length=3; assert Abort during the second READ -> only Dst+0 is written; no Done pulse; Busy low next cycle; a following Start is accepted.
- Drive Reset_n low during a WRITE cycle -> MemWrite, Busy and Adresa go to 0 without waiting for a clock edge; state is IDLE after Reset_n is released.
- mem[0x20]=0xABCD; Start with Src=0x20, Dst=0x21, Length=3; pulse Start again mid-transfer -> mem[0x21..0x23]=0xABCD; the second Start is ignored (single Done, WordsDone=3).
